// File: rtl/hazard_pkg.sv
// Shared encodings and the register-match helper for the MIPS hazard unit.
// Combinational definitions only; no state, no backpressure.
package hazard_pkg;

    localparam int ADDR_W = 5;

    localparam logic [1:0] BR_NONE = 2'd0;
    localparam logic [1:0] BR_BEQ  = 2'd1;
    localparam logic [1:0] BR_BNE  = 2'd2;

    localparam logic [1:0] MD_NONE = 2'd0;
    localparam logic [1:0] MD_MUL  = 2'd1;
    localparam logic [1:0] MD_DIV  = 2'd2;

    // D-stage (branch comparator) and E-stage (ALU) muxes order their inputs differently.
    localparam logic [1:0] FWD_D_RF = 2'd0;
    localparam logic [1:0] FWD_D_M  = 2'd1;
    localparam logic [1:0] FWD_D_W  = 2'd2;
    localparam logic [1:0] FWD_E_RF = 2'd0;
    localparam logic [1:0] FWD_E_W  = 2'd1;
    localparam logic [1:0] FWD_E_M  = 2'd2;

    // $0 is hardwired to zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] wr_addr,
                                       input logic              wr_en);
        return wr_en && (addr != '0) && (addr == wr_addr);
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Multiply/divide occupancy timer: loads the op latency when an MDU op is in E.
// Busy flag is registered (timer != 0); no backpressure, a new load overrides.
// Busy reads 0 while reset is asserted.
module md_busy_timer
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] md_op,
    output logic       busy
);

    logic [CNT_W-1:0] timer;

    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (md_op == MD_MUL) begin
            timer <= CNT_W'(MUL_LAT);
        end else if (md_op == MD_DIV) begin
            timer <= CNT_W'(DIV_LAT);
        end else if (timer != '0) begin
            timer <= timer - CNT_W'(1);
        end
    end

    assign busy = (timer != '0) && !rst;

endmodule

// File: rtl/hazard_unit_mc.sv
// Stall/flush/forwarding control for the 5-stage pipeline with a multi-cycle MDU.
// Stall, flush and forward selects are combinational; MdBusy and StallCount are registered.
// A stall freezes F/D and bubbles E; the stall counter saturates at all-ones.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MUL_LAT    = 4,
    parameter int DIV_LAT    = 32,
    parameter int CNT_W      = 6,
    parameter int PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            BranchD,
    input  logic [1:0]            PCSrcD,
    input  logic [REG_ADDR_W-1:0] RsD,
    input  logic [REG_ADDR_W-1:0] RtD,
    input  logic [REG_ADDR_W-1:0] RsE,
    input  logic [REG_ADDR_W-1:0] RtE,
    input  logic [REG_ADDR_W-1:0] WriteRegE,
    input  logic [REG_ADDR_W-1:0] WriteRegM,
    input  logic [REG_ADDR_W-1:0] WriteRegW,
    input  logic                  RegWriteE,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  MemtoRegE,
    input  logic                  MemtoRegM,
    input  logic [1:0]            MdOpD,
    input  logic [1:0]            MdOpE,
    input  logic                  MdReadD,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  FlushE,
    output logic [1:0]            ForwardAD,
    output logic [1:0]            ForwardBD,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  MdBusy,
    output logic [PERF_W-1:0]     StallCount
);

    logic br_active, md_in_e, md_need_d;
    logic lwstall, brstall, mdstall, hz;

    md_busy_timer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_md_timer (
        .clk   (clk),
        .rst   (rst),
        .md_op (MdOpE),
        .busy  (MdBusy)
    );

    always_comb begin
        br_active = (BranchD == BR_BEQ) || (BranchD == BR_BNE);
        md_in_e   = (MdOpE == MD_MUL) || (MdOpE == MD_DIV);
        md_need_d = MdReadD || (MdOpD == MD_MUL) || (MdOpD == MD_DIV);

        ForwardAE = reg_match(RsE, WriteRegM, RegWriteM) ? FWD_E_M :
                    reg_match(RsE, WriteRegW, RegWriteW) ? FWD_E_W : FWD_E_RF;
        ForwardBE = reg_match(RtE, WriteRegM, RegWriteM) ? FWD_E_M :
                    reg_match(RtE, WriteRegW, RegWriteW) ? FWD_E_W : FWD_E_RF;

        ForwardAD = FWD_D_RF;
        ForwardBD = FWD_D_RF;
        if (br_active) begin
            ForwardAD = reg_match(RsD, WriteRegM, RegWriteM) ? FWD_D_M :
                        reg_match(RsD, WriteRegW, RegWriteW) ? FWD_D_W : FWD_D_RF;
            ForwardBD = reg_match(RtD, WriteRegM, RegWriteM) ? FWD_D_M :
                        reg_match(RtD, WriteRegW, RegWriteW) ? FWD_D_W : FWD_D_RF;
        end

        lwstall = MemtoRegE && (reg_match(RsD, RtE, 1'b1) || reg_match(RtD, RtE, 1'b1));
        // Branches resolve in D, so an ALU result in E or a load in M is not yet available.
        brstall = br_active &&
                  (reg_match(RsD, WriteRegE, RegWriteE) || reg_match(RtD, WriteRegE, RegWriteE) ||
                   reg_match(RsD, WriteRegM, MemtoRegM) || reg_match(RtD, WriteRegM, MemtoRegM));
        mdstall = (MdBusy || md_in_e) && md_need_d;

        hz     = lwstall || brstall || mdstall;
        StallF = hz && !rst;
        StallD = hz || rst;
        FlushE = hz || (PCSrcD != 2'd0) || rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            StallCount <= '0;
        end else if (hz && (StallCount != '1)) begin
            StallCount <= StallCount + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Table vectors, hand sequences and random stimulus against a behavioural model.
module tb_hazard_unit_mc;

    typedef struct packed {
        logic [1:0] BranchD;
        logic [1:0] PCSrcD;
        logic [4:0] RsD;
        logic [4:0] RtD;
        logic [4:0] RsE;
        logic [4:0] RtE;
        logic [4:0] wrE;
        logic [4:0] wrM;
        logic [4:0] wrW;
        logic       rwE;
        logic       rwM;
        logic       rwW;
        logic       mtoE;
        logic       mtoM;
        logic [1:0] MdOpD;
        logic [1:0] MdOpE;
        logic       MdReadD;
    } in_t;

    typedef struct packed {
        logic       stf;
        logic       std;
        logic       fle;
        logic [1:0] fad;
        logic [1:0] fbd;
        logic [1:0] fae;
        logic [1:0] fbe;
    } ex_t;

    typedef struct {
        string name;
        in_t   in;
        ex_t   ex;
    } tv_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    in_t        cur = '0;
    logic       StallF, StallD, FlushE, MdBusy;
    logic [1:0] ForwardAD, ForwardBD, ForwardAE, ForwardBE;
    logic [7:0] StallCount;

    int nvec = 0;
    int nmis = 0;
    int m_timer = 0;
    int m_cnt = 0;
    bit cnt_known = 1'b0;
    logic last_sd, last_busy;

    always #5 clk = ~clk;

    hazard_unit_mc #(.PERF_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .BranchD    (cur.BranchD),
        .PCSrcD     (cur.PCSrcD),
        .RsD        (cur.RsD),
        .RtD        (cur.RtD),
        .RsE        (cur.RsE),
        .RtE        (cur.RtE),
        .WriteRegE  (cur.wrE),
        .WriteRegM  (cur.wrM),
        .WriteRegW  (cur.wrW),
        .RegWriteE  (cur.rwE),
        .RegWriteM  (cur.rwM),
        .RegWriteW  (cur.rwW),
        .MemtoRegE  (cur.mtoE),
        .MemtoRegM  (cur.mtoM),
        .MdOpD      (cur.MdOpD),
        .MdOpE      (cur.MdOpE),
        .MdReadD    (cur.MdReadD),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushE     (FlushE),
        .ForwardAD  (ForwardAD),
        .ForwardBD  (ForwardBD),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .MdBusy     (MdBusy),
        .StallCount (StallCount)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit hit(int src, int dst, bit en);
        return en && (src != 0) && (src == dst);
    endfunction

    function automatic int fwd_sel(int src, bit in_d, in_t i);
        // D mux: M=1, W=2; E mux: M=2, W=1.
        if (hit(src, i.wrM, i.rwM)) return in_d ? 1 : 2;
        if (hit(src, i.wrW, i.rwW)) return in_d ? 2 : 1;
        return 0;
    endfunction

    function automatic bit model_hz(in_t i, bit r, int tmr);
        bit br, lw, bs, ms, busy;
        br   = (i.BranchD == 2'd1) || (i.BranchD == 2'd2);
        lw   = i.mtoE && (hit(i.RsD, i.RtE, 1'b1) || hit(i.RtD, i.RtE, 1'b1));
        bs   = br && (hit(i.RsD, i.wrE, i.rwE) || hit(i.RtD, i.wrE, i.rwE) ||
                      hit(i.RsD, i.wrM, i.mtoM) || hit(i.RtD, i.wrM, i.mtoM));
        busy = (tmr > 0) && !r;
        ms   = (busy || i.MdOpE == 2'd1 || i.MdOpE == 2'd2) &&
               (i.MdReadD || i.MdOpD == 2'd1 || i.MdOpD == 2'd2);
        return lw || bs || ms;
    endfunction

    function automatic ex_t mk_ex(int stf, int std, int fle, int fad, int fbd, int fae, int fbe);
        ex_t e;
        e.stf = 1'(stf); e.std = 1'(std); e.fle = 1'(fle);
        e.fad = 2'(fad); e.fbd = 2'(fbd); e.fae = 2'(fae); e.fbe = 2'(fbe);
        return e;
    endfunction

    task automatic check_all();
        bit h, br;
        h  = model_hz(cur, rst, m_timer);
        br = (cur.BranchD == 2'd1) || (cur.BranchD == 2'd2);
        chk("StallF", StallF, h && !rst);
        chk("StallD", StallD, h || rst);
        chk("FlushE", FlushE, h || (cur.PCSrcD != 0) || rst);
        chk("ForwardAD", ForwardAD, br ? fwd_sel(cur.RsD, 1'b1, cur) : 0);
        chk("ForwardBD", ForwardBD, br ? fwd_sel(cur.RtD, 1'b1, cur) : 0);
        chk("ForwardAE", ForwardAE, fwd_sel(cur.RsE, 1'b0, cur));
        chk("ForwardBE", ForwardBE, fwd_sel(cur.RtE, 1'b0, cur));
        chk("MdBusy", MdBusy, (m_timer > 0) && !rst);
        if (cnt_known) chk("StallCount", StallCount, m_cnt);
    endtask

    task automatic model_update();
        bit h;
        h = model_hz(cur, rst, m_timer);
        if (rst) begin
            m_timer = 0; m_cnt = 0; cnt_known = 1'b1;
        end else begin
            if (cur.MdOpE == 2'd1)      m_timer = 4;
            else if (cur.MdOpE == 2'd2) m_timer = 32;
            else if (m_timer > 0)       m_timer--;
            if (h && m_cnt < 255) m_cnt++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        last_sd   = StallD;
        last_busy = MdBusy;
        @(posedge clk);
        model_update();
        #1;
    endtask

    tv_t tab[13];

    initial begin
        int nsd, nb, guard;

        tab[0]  = '{"loaduse",     '{default:'0, mtoE:1'b1, RtE:5'd8, RsD:5'd8},              mk_ex(1,1,1,0,0,0,0)};
        tab[1]  = '{"loaduse_r0",  '{default:'0, mtoE:1'b1},                                   mk_ex(0,0,0,0,0,0,0)};
        tab[2]  = '{"fwdE_MoverW", '{default:'0, rwM:1'b1, rwW:1'b1, wrM:5'd9, wrW:5'd9, RsE:5'd9}, mk_ex(0,0,0,0,0,2,0)};
        tab[3]  = '{"fwdD_W",      '{default:'0, BranchD:2'd1, RtD:5'd9, RsD:5'd3, rwW:1'b1, wrW:5'd9}, mk_ex(0,0,0,0,2,0,0)};
        tab[4]  = '{"brstall_E",   '{default:'0, BranchD:2'd2, rwE:1'b1, wrE:5'd5, RtD:5'd5},  mk_ex(1,1,1,0,0,0,0)};
        tab[5]  = '{"brstall_M",   '{default:'0, BranchD:2'd2, mtoM:1'b1, wrM:5'd5, RtD:5'd5}, mk_ex(1,1,1,0,0,0,0)};
        tab[6]  = '{"br_fwdM",     '{default:'0, BranchD:2'd2, rwM:1'b1, wrM:5'd5, RtD:5'd5},  mk_ex(0,0,0,0,1,0,0)};
        tab[7]  = '{"taken_only",  '{default:'0, PCSrcD:2'd1},                                 mk_ex(0,0,1,0,0,0,0)};
        tab[8]  = '{"taken_hz",    '{default:'0, PCSrcD:2'd1, BranchD:2'd1, rwE:1'b1, wrE:5'd5, RsD:5'd5}, mk_ex(1,1,1,0,0,0,0)};
        tab[9]  = '{"fwdE_W",      '{default:'0, rwW:1'b1, wrW:5'd4, RsE:5'd4, rwM:1'b1, wrM:5'd7, RtE:5'd7}, mk_ex(0,0,0,0,0,1,2)};
        tab[10] = '{"r0_nofwd",    '{default:'0, rwM:1'b1, rwW:1'b1},                          mk_ex(0,0,0,0,0,0,0)};
        tab[11] = '{"nobranch3",   '{default:'0, BranchD:2'd3, rwE:1'b1, wrE:5'd5, RsD:5'd5, rwM:1'b1, wrM:5'd5}, mk_ex(0,0,0,0,0,0,0)};
        tab[12] = '{"fwdD_MoverW", '{default:'0, BranchD:2'd1, RsD:5'd6, rwM:1'b1, wrM:5'd6, rwW:1'b1, wrW:5'd6}, mk_ex(0,0,0,1,0,0,0)};

        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_StallD", StallD, 1);
            chk("rst_FlushE", FlushE, 1);
            chk("rst_StallF", StallF, 0);
            chk("rst_MdBusy", MdBusy, 0);
            @(posedge clk);
            model_update();
            #1;
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_outs", {StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE, MdBusy}, 0);
        chk("post_rst_cnt", StallCount, 0);
        @(posedge clk);
        model_update();
        #1;

        for (int i = 0; i < 13; i++) begin
            cur = tab[i].in;
            @(negedge clk);
            chk({"tab_", tab[i].name}, {StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE}, tab[i].ex);
            check_all();
            @(posedge clk);
            model_update();
            #1;
            if (i == 0) chk("cnt_after_loaduse", StallCount, 1);
        end

        // Divide followed by a dependent mfhi held in D.
        cur = '0; cur.MdOpE = 2'd2; cur.MdReadD = 1'b1;
        nsd = 0; nb = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            cur.MdOpE = 2'd0;
            nsd += int'(last_sd);
            nb  += int'(last_busy);
            if (i == 33) chk("div_release", last_sd, 0);
        end
        chk("div_stall_cycles", nsd, 33);
        chk("div_busy_cycles", nb, 32);

        cur = '0; cur.MdOpE = 2'd1; cur.MdReadD = 1'b1;
        nsd = 0; nb = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            cur.MdOpE = 2'd0;
            nsd += int'(last_sd);
            nb  += int'(last_busy);
        end
        chk("mul_stall_cycles", nsd, 5);
        chk("mul_busy_cycles", nb, 4);

        // Reset while a divide is in flight (timer at 20).
        cur = '0; cur.MdOpE = 2'd2;
        step();
        cur.MdOpE = 2'd0;
        for (int i = 0; i < 12; i++) step();
        chk("mid_div_busy", MdBusy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_div_rst_busy", MdBusy, 0);
        chk("mid_div_rst_cnt", StallCount, 0);
        @(posedge clk);
        model_update();
        #1;

        // Drive the counter to all-ones minus 1, then three more stalls.
        cur = '0; cur.mtoE = 1'b1; cur.RtE = 5'd8; cur.RsD = 5'd8;
        guard = 0;
        while (m_cnt < 254 && guard < 400) begin
            step();
            guard++;
        end
        chk("cnt_pre_sat", StallCount, 254);
        for (int i = 0; i < 3; i++) step();
        chk("cnt_saturated", StallCount, 255);

        for (int i = 0; i < 500; i++) begin
            cur.BranchD = 2'($urandom_range(0, 3));
            cur.PCSrcD  = 2'($urandom_range(0, 3));
            cur.RsD     = 5'($urandom_range(0, 3));
            cur.RtD     = 5'($urandom_range(0, 3));
            cur.RsE     = 5'($urandom_range(0, 3));
            cur.RtE     = 5'($urandom_range(0, 3));
            cur.wrE     = 5'($urandom_range(0, 3));
            cur.wrM     = 5'($urandom_range(0, 3));
            cur.wrW     = 5'($urandom_range(0, 3));
            cur.rwE     = 1'($urandom_range(0, 1));
            cur.rwM     = 1'($urandom_range(0, 1));
            cur.rwW     = 1'($urandom_range(0, 1));
            cur.mtoE    = 1'($urandom_range(0, 1));
            cur.mtoM    = 1'($urandom_range(0, 1));
            cur.MdOpD   = 2'($urandom_range(0, 2));
            cur.MdOpE   = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
            cur.MdReadD = 1'($urandom_range(0, 1));
            rst         = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
Hazard and forwarding controller for the 5-stage MIPS pipeline, extended to cover a multi-cycle multiply/divide unit (MDU) that writes HI/LO. It generates the F/D stall, E flush and D/E forwarding selects, and tracks MDU occupancy with an internal latency timer. It also keeps a saturating stall-cycle performance counter. It sits beside the datapath and takes register addresses and control bits from the D, E, M and W stages.

Parameters:
REG_ADDR_W, 5, register address width
MUL_LAT, 4, MDU cycles for mult/multu (>=1)
DIV_LAT, 32, MDU cycles for div/divu (>=1, >=MUL_LAT)
CNT_W, 6, MDU timer width; must satisfy 2^CNT_W > DIV_LAT
PERF_W, 32, stall counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
BranchD  in  2  1=beq, 2=bne, other=no branch
PCSrcD  in  2  nonzero = control transfer taken in D
RsD, RtD, RsE, RtE  in  REG_ADDR_W  source registers
WriteRegE, WriteRegM, WriteRegW  in  REG_ADDR_W  destination registers
RegWriteE, RegWriteM, RegWriteW  in  1  stage writes the register file
MemtoRegE, MemtoRegM  in  1  stage is a load
MdOpD, MdOpE  in  2  0=none, 1=mult, 2=div, 3=reserved (treated as none)
MdReadD  in  1  D instruction is mfhi/mflo
StallF, StallD  out  1  hold the PC and the IF/ID register
FlushE  out  1  clear the ID/EX register
ForwardAD, ForwardBD  out  2  0=regfile, 1=M result, 2=W result
ForwardAE, ForwardBE  out  2  0=regfile, 1=W result, 2=M result
MdBusy  out  1  MDU timer nonzero
StallCount  out  PERF_W  saturating count of hazard-stall cycles

Behaviour:
- Reset: timer=0 and StallCount=0 on the first clk edge with rst=1. While rst=1: StallD=1, FlushE=1, StallF=0, MdBusy=0, and all Forward* outputs are computed normally.
- Register 0 is never a forwarding match or a hazard match. Every compare also requires the source address != 0.
- ForwardAE: 2 if RegWriteM and WriteRegM==RsE; else 1 if RegWriteW and WriteRegW==RsE; else 0. ForwardBE is the same using RtE. M takes priority over W.
- ForwardAD/BD apply only when BranchD is 1 or 2; otherwise they are 0. Select 1 if RegWriteM and WriteRegM==RsD (RtD for B); else 2 if RegWriteW and WriteRegW==RsD (RtD for B). The W compare uses its own operand.
- The load-use hazard lwstall is set when MemtoRegE and RtE equals RsD or RtD.
- The branch hazard brstall is set when BranchD is 1 or 2 and either of these holds:
  - RegWriteE and WriteRegE equals RsD or RtD;
  - MemtoRegM and WriteRegM equals RsD or RtD.
- MDU timer (registered):
  - When MdOpE=1 the timer loads MUL_LAT. When MdOpE=2 it loads DIV_LAT.
  - Otherwise, if the timer is nonzero, it decrements by 1.
  - A load in the same cycle overrides the decrement.
- MdBusy = (timer != 0).
- mdstall is set when MdBusy or MdOpE != 0, and MdReadD=1 or MdOpD is 1 or 2.
- Release timing: with timer==1 in cycle t, the timer is 0 in t+1 and the dependent D instruction proceeds in t+1.
- Stall outputs:
  - hz = lwstall | brstall | mdstall.
  - StallF = hz & ~rst.
  - StallD = hz | rst.
- FlushE = hz | (PCSrcD != 0) | rst. A stall always inserts a bubble into E.
- StallCount increments by 1 on each cycle with hz=1 and rst=0. It holds at all-ones and never wraps.
- Simultaneous events: a taken branch coincident with hz still stalls, and FlushE=1. An MdOpE start while busy is impossible by construction (mdstall). If it happens anyway, the new load wins.
- Latency: all outputs except MdBusy and StallCount are combinational in the current cycle.

Decomposition:
- hazard_pkg holds:
  - the BranchD codes (BR_NONE/BR_BEQ/BR_BNE);
  - the MdOp codes (MD_NONE/MD_MUL/MD_DIV);
  - the forward-select localparams for D and E (FWD_RF, FWD_M, FWD_W; note the E and D encodings differ);
  - a function reg_match(addr, wr_addr, wr_en) that includes the $0 exclusion.
- One sub-module, md_busy_timer, contains the timer, MdBusy and the load/decrement logic, parametrised by MUL_LAT, DIV_LAT and CNT_W.

Test Plan:
- Reset held 3 cycles, then released with all inputs 0 -> StallD=1 and FlushE=1 during reset; StallCount=0 and MdBusy=0 after reset; all outputs 0.
- Load-use: MemtoRegE=1, RtE=8, RsD=8 -> StallF=StallD=FlushE=1 for one cycle; StallCount goes 0->1. The same case with RtE=0 and RsD=0 -> no stall.
- Forwarding priority: RegWriteM=RegWriteW=1, WriteRegM=WriteRegW=9, RsE=9 -> ForwardAE=2. With BranchD=1 and RtD=9, RegWriteM=0 -> ForwardBD=2, and ForwardAD=0 when RsD=3.
- Branch stall: BranchD=2, RegWriteE=1, WriteRegE=5, RtD=5 -> stall. Next cycle with MemtoRegM=1, WriteRegM=5 -> stall. Third cycle with only RegWriteM=1 -> no stall, ForwardBD=1.
- Divide: MdOpE=2 pulse, then MdReadD=1 held -> MdBusy high for exactly 32 cycles, StallD high 33 cycles, StallD low on the cycle the timer reads 0. Same test with MdOpE=1 -> 5 stall cycles.
- Reset mid-divide at timer=20 -> timer=0 and MdBusy=0 next cycle. Force the stall counter to all-ones minus 1, then stall 3 cycles -> StallCount ends at all-ones.
